// File: rtl/move_entry.sv
// Keypad move entry: debounces the held key code, turns accepted key presses
// into column/pop-mode selections, and offers a move to the game logic over a
// valid/ready handshake.
// Optional feature macro: MOVE_ENTRY_AUTO_COMMIT_EN (a column key commits the
// move immediately instead of waiting for key F).
module move_entry #(
  parameter int unsigned STABLE_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [2:0] move_col,
  output logic       move_pop,
  output logic       sel_valid,
  output logic [2:0] sel_col,
  output logic       pop_mode
);

  localparam int unsigned CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [3:0] KEY_POP    = 4'h0;
  localparam logic [3:0] KEY_CLR    = 4'hE;
  localparam logic [3:0] KEY_COMMIT = 4'hF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Debounce state
  logic [3:0]       key_q, key_d;
  logic [3:0]       key_prev_q, key_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;
  logic [3:0]       last_q, last_d;
  logic             key_same;
  logic             key_evt;
  logic             key_is_col;
  logic [2:0]       key_col;

  // Move / selection state
  state_e     state_q, state_d;
  logic       move_valid_q, move_valid_d;
  logic [2:0] move_col_q, move_col_d;
  logic       move_pop_q, move_pop_d;
  logic       sel_valid_q, sel_valid_d;
  logic [2:0] sel_col_q, sel_col_d;
  logic       pop_mode_q, pop_mode_d;

  assign key_same   = (key_q == key_prev_q);
  assign key_is_col = (key_q >= 4'h1) && (key_q <= 4'h7);
  assign key_col    = 3'(key_q - 4'h1);

  // Stability counter, priming and single-cycle key event generation
  always_comb begin
    key_d      = key_code;
    key_prev_d = key_q;
    cnt_d      = cnt_q;
    primed_d   = primed_q;
    last_d     = last_q;
    key_evt    = 1'b0;

    if (!key_same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // The code has just become stable: the first one after reset only primes.
    if (key_same && (cnt_q == CNT_HIT)) begin
      if (!primed_q) begin
        primed_d = 1'b1;
        last_d   = key_q;
      end else if (key_q != last_q) begin
        key_evt = 1'b1;
        last_d  = key_q;
      end
    end
  end

  // Next-state and registered-output logic of the entry FSM
  always_comb begin
    state_d      = state_q;
    move_valid_d = move_valid_q;
    move_col_d   = move_col_q;
    move_pop_d   = move_pop_q;
    sel_valid_d  = sel_valid_q;
    sel_col_d    = sel_col_q;
    pop_mode_d   = pop_mode_q;

    case (state_q)
      IDLE: begin
        if (key_evt) begin
          if (key_is_col) begin
            sel_col_d   = key_col;
            sel_valid_d = 1'b1;
`ifdef MOVE_ENTRY_AUTO_COMMIT_EN
            move_col_d   = key_col;
            move_pop_d   = pop_mode_q;
            move_valid_d = 1'b1;
            state_d      = ISSUE;
`endif
          end else if (key_q == KEY_POP) begin
            pop_mode_d = ~pop_mode_q;
          end else if (key_q == KEY_CLR) begin
            sel_valid_d = 1'b0;
            pop_mode_d  = 1'b0;
          end else if (key_q == KEY_COMMIT) begin
`ifndef MOVE_ENTRY_AUTO_COMMIT_EN
            if (sel_valid_q) begin
              move_col_d   = sel_col_q;
              move_pop_d   = pop_mode_q;
              move_valid_d = 1'b1;
              state_d      = ISSUE;
            end
`endif
          end
        end
      end
      ISSUE: begin
        // Key events here only refresh the last accepted code.
        if (move_valid_q && move_ready) begin
          state_d      = IDLE;
          move_valid_d = 1'b0;
          move_col_d   = 3'd0;
          move_pop_d   = 1'b0;
          sel_valid_d  = 1'b0;
          pop_mode_d   = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        move_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q        <= 4'h0;
      key_prev_q   <= 4'h0;
      cnt_q        <= '0;
      primed_q     <= 1'b0;
      last_q       <= 4'h0;
      state_q      <= IDLE;
      move_valid_q <= 1'b0;
      move_col_q   <= 3'd0;
      move_pop_q   <= 1'b0;
      sel_valid_q  <= 1'b0;
      sel_col_q    <= 3'd0;
      pop_mode_q   <= 1'b0;
    end else begin
      key_q        <= key_d;
      key_prev_q   <= key_prev_d;
      cnt_q        <= cnt_d;
      primed_q     <= primed_d;
      last_q       <= last_d;
      state_q      <= state_d;
      move_valid_q <= move_valid_d;
      move_col_q   <= move_col_d;
      move_pop_q   <= move_pop_d;
      sel_valid_q  <= sel_valid_d;
      sel_col_q    <= sel_col_d;
      pop_mode_q   <= pop_mode_d;
    end
  end

  assign move_valid = move_valid_q;
  assign move_col   = move_col_q;
  assign move_pop   = move_pop_q;
  assign sel_valid  = sel_valid_q;
  assign sel_col    = sel_col_q;
  assign pop_mode   = pop_mode_q;

endmodule

// File: tb/tb_move_entry.sv
// Scoreboard bench for move_entry with a key-press level reference model.
module tb_move_entry;

  localparam int unsigned S = 4;
  localparam int HOLD = 7;

  logic       clk;
  logic       rst;
  logic [3:0] key_code;
  logic       move_ready;
  logic       move_valid;
  logic [2:0] move_col;
  logic       move_pop;
  logic       sel_valid;
  logic [2:0] sel_col;
  logic       pop_mode;

  move_entry #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_col   (move_col),
    .move_pop   (move_pop),
    .sel_valid  (sel_valid),
    .sel_col    (sel_col),
    .pop_mode   (pop_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] col;
    logic       pop;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic mv_prev = 1'b0;

  // Reference model state (key-press granularity)
  logic       m_primed;
  logic [3:0] m_last;
  logic       m_sel_valid;
  logic [2:0] m_sel_col;
  logic       m_pop;
  logic       m_issue;
  int         run_start;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_primed    = 1'b0;
    m_last      = 4'h0;
    m_sel_valid = 1'b0;
    m_sel_col   = 3'd0;
    m_pop       = 1'b0;
    m_issue     = 1'b0;
    sb.delete();
  endtask

  task automatic model_push(input logic [2:0] col, input logic pop);
    exp_t e;
    e.col   = col;
    e.pop   = pop;
    e.due   = run_start + int'(S) + 2;
    m_issue = 1'b1;
    sb.push_back(e);
  endtask

  // Effect of one accepted (stable) key code
  task automatic model_key(input logic [3:0] c);
    logic [2:0] col;
    if (!m_primed) begin
      m_primed = 1'b1;
      m_last   = c;
      return;
    end
    if (c == m_last) return;
    m_last = c;
    if (m_issue) return;
    col = 3'(c - 4'h1);
    if (c >= 4'h1 && c <= 4'h7) begin
      m_sel_valid = 1'b1;
      m_sel_col   = col;
`ifdef MOVE_ENTRY_AUTO_COMMIT_EN
      model_push(col, m_pop);
`endif
    end else if (c == 4'h0) begin
      m_pop = ~m_pop;
    end else if (c == 4'hE) begin
      m_sel_valid = 1'b0;
      m_pop       = 1'b0;
    end else if (c == 4'hF) begin
`ifndef MOVE_ENTRY_AUTO_COMMIT_EN
      if (m_sel_valid) model_push(m_sel_col, m_pop);
`endif
    end
  endtask

  task automatic check_levels();
    chk("move_valid", int'(move_valid), int'(m_issue));
    chk("sel_valid", int'(sel_valid), int'(m_sel_valid));
    if (m_sel_valid) chk("sel_col", int'(sel_col), int'(m_sel_col));
    chk("pop_mode", int'(pop_mode), int'(m_pop));
  endtask

  // Hold a code long enough to be accepted, then check the visible state
  task automatic press(input logic [3:0] c);
    if (c != key_code) run_start = cyc;
    key_code = c;
    model_key(c);
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
    check_levels();
  endtask

  // Hold a code too briefly to be accepted
  task automatic glitch(input logic [3:0] c, input int n);
    if (c != key_code) run_start = cyc;
    key_code = c;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ready_pulse();
    move_ready = 1'b1;
    if (m_issue) begin
      m_issue     = 1'b0;
      m_sel_valid = 1'b0;
      m_pop       = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    move_ready = 1'b0;
    check_levels();
  endtask

  // One-cycle reset pulse; code c is held across it
  task automatic do_reset(input logic [3:0] c);
    rst        = 1'b1;
    move_ready = 1'b0;
    key_code   = c;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_start = cyc;
    chk("rst_move_valid", int'(move_valid), 0);
    chk("rst_move_col", int'(move_col), 0);
    chk("rst_move_pop", int'(move_pop), 0);
    chk("rst_sel_valid", int'(sel_valid), 0);
    chk("rst_sel_col", int'(sel_col), 0);
    chk("rst_pop_mode", int'(pop_mode), 0);
  endtask

  // Monitor: pops an expectation on each new offer and checks it while held
  always @(negedge clk) begin
    if (move_valid && !mv_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_move", 1, 0);
        cur.col = move_col;
        cur.pop = move_pop;
        cur.due = cyc;
      end else begin
        cur = sb.pop_front();
        chk("move_latency", cyc, cur.due);
      end
    end
    if (move_valid) begin
      chk("move_col", int'(move_col), int'(cur.col));
      chk("move_pop", int'(move_pop), int'(cur.pop));
    end
    mv_prev = move_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] c;
    int r;
    rst        = 1'b1;
    key_code   = 4'h3;
    move_ready = 1'b0;
    model_reset();
    run_start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Priming, select 5, commit, handshake
    do_reset(4'h3);
    press(4'h3);
    press(4'h5);
    press(4'hF);
    ready_pulse();

    // Glitch rejection
    glitch(4'h2, 3);
    press(4'h6);

    // Pop move with a long stall and keys discarded during it
    press(4'h0);
    press(4'h1);
    press(4'hF);
    press(4'h7);
    press(4'hE);
    ready_pulse();

    // Commit without a selection, and after a clear
    press(4'hF);
    press(4'h4);
    press(4'hE);
    press(4'hF);

    // Reset while a move is offered
    press(4'h2);
    press(4'hF);
    do_reset(4'h5);
    press(4'h5);
    press(4'h3);
    press(4'h7);
    ready_pulse();

    // Ready while idle has no effect
    ready_pulse();

    // Randomized key sequences
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        c = 4'($urandom_range(0, 15));
        glitch(c, int'($urandom_range(1, 3)));
      end
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: c = 4'($urandom_range(1, 7));
        4:          c = 4'h0;
        5:          c = 4'hE;
        6, 7:       c = 4'hF;
        8:          c = 4'($urandom_range(8, 13));
        default:    c = 4'($urandom_range(0, 15));
      endcase
      press(c);
      if ($urandom_range(0, 2) == 0) ready_pulse();
      if ($urandom_range(0, 40) == 0) begin
        c = 4'($urandom_range(1, 15));
        do_reset(c);
        press(c);
      end
    end

    ready_pulse();
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/move_entry.md
MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 200000, meaning clocks a changed key code must stay constant before acceptance (2 ms at 100 MHz).
REQ-002 SHALL have port clk  input  1  100 MHz onboard clock, sole clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port key_code  input  4  held key code from the keypad decoder (0-9, A-F).
REQ-005 SHALL have port move_ready  input  1  game logic accepts the offered move this cycle.
REQ-006 SHALL have port move_valid  output  1  move offered; held until handshake.
REQ-007 SHALL have port move_col  output  3  offered column, 0-6.
REQ-008 SHALL have port move_pop  output  1  offered move is a pop (1) or a drop (0).
REQ-009 SHALL have port sel_valid  output  1  a column is currently selected.
REQ-010 SHALL have port sel_col  output  3  currently selected column, 0-6.
REQ-011 SHALL have port pop_mode  output  1  pop mode armed for the next move.

Function
REQ-012 SHALL register key_code once before use; all comparisons use the registered value.
REQ-013 SHALL reload the stability counter to 0 whenever the registered code differs from the previous cycle, else increment, saturating at STABLE_CYCLES.
REQ-014 SHALL raise one internal key event, one cycle wide, when the counter reaches STABLE_CYCLES and the code differs from the last accepted code; the last accepted code then updates.
REQ-015 SHALL treat the first stable code after reset as priming only: recorded as last accepted code, no event.
REQ-016 SHALL implement FSM states IDLE and ISSUE; reset state IDLE.
REQ-017 In IDLE, SHALL act on events as follows: code 1-7 sets sel_col = code-1 and sel_valid = 1, overwriting any prior selection.
REQ-018 In IDLE, code 0 SHALL toggle pop_mode.
REQ-019 In IDLE, code F SHALL, if sel_valid = 1, load move_col = sel_col and move_pop = pop_mode and enter ISSUE the next cycle; if sel_valid = 0, F is ignored.
REQ-020 In IDLE, code E SHALL clear sel_valid and pop_mode.
REQ-021 In IDLE, codes 8, 9, A-D SHALL be ignored.
REQ-022 In ISSUE, move_valid SHALL be 1, with move_col and move_pop stable until handshake.
REQ-023 A handshake (move_valid and move_ready in one cycle) SHALL return the FSM to IDLE, clear move_valid, sel_valid and pop_mode the next cycle.
REQ-024 In ISSUE, key events SHALL update the last accepted code but otherwise be discarded.
REQ-025 move_ready while in IDLE SHALL have no effect.
REQ-026 Latency SHALL be fixed: F accepted on cycle N -> move_valid = 1 on cycle N+1.

Reset
REQ-027 On rst, SHALL clear move_valid, move_col, move_pop, sel_valid, sel_col, pop_mode, the stability counter, and the priming flag, and enter IDLE.
REQ-028 rst asserted mid-ISSUE SHALL drop move_valid the next cycle; no move is delivered.

Configuration
REQ-029 Macro MOVE_ENTRY_AUTO_COMMIT_EN defined: a 1-7 event in IDLE SHALL load move_col = code-1, move_pop = pop_mode and enter ISSUE directly. F is then ignored and sel_valid/sel_col still reflect the column.
REQ-030 Macro undefined: commit SHALL require F per REQ-019.

Verification (STABLE_CYCLES = 4)
REQ-031 After reset, key_code = 3 held -> primed only, no selection. Then key_code 5 then F, each held 6 cycles -> sel_col = 4, then move_valid = 1, move_col = 4, move_pop = 0; move_ready = 1 -> all cleared the next cycle.
REQ-032 key_code 2 held 3 cycles, then 6 held 6 cycles -> no event for 2, sel_col = 5 (glitch rejection).
REQ-033 Sequence 0, 1, F with move_ready low for 10 cycles -> move_valid held with move_col = 0, move_pop = 1 for all 10 cycles; codes 7 and E entered during the stall are discarded.
REQ-034 F entered with no selection -> no move_valid. Then 4, E, F -> still no move_valid, sel_valid = 0.
REQ-035 rst pulsed while move_valid = 1 -> move_valid = 0 the next cycle; the next stable code only primes.
REQ-036 Build with MOVE_ENTRY_AUTO_COMMIT_EN, key_code 7 -> move_valid = 1, move_col = 6 without F.
